// File: rtl/is_uart_hex_tx_seq.sv
// Prints one latched word as uppercase ASCII hex (MS nibble first) plus CR LF
// over a valid/ready byte stream. Define IS_HEX_PREFIX_EN to prepend "0x".
module is_uart_hex_tx_seq #(
    parameter int NIBBLES = 8,
    parameter int DATA_W  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [4*NIBBLES-1:0]   word_i,
    input  logic                   word_valid_i,
    output logic                   word_ready_o,
    output logic [DATA_W-1:0]      tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);
    localparam logic [DATA_W-1:0] CH_CR = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CH_LF = DATA_W'(8'h0A);
`ifdef IS_HEX_PREFIX_EN
    localparam logic [DATA_W-1:0] CH_0 = DATA_W'(8'h30);
    localparam logic [DATA_W-1:0] CH_X = DATA_W'(8'h78);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef IS_HEX_PREFIX_EN
        S_PFX0,
        S_PFX1,
`endif
        S_NIB,
        S_CR,
        S_LF
    } state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic [W-1:0]        word_q, word_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                valid_nx;
    logic                xfer;

    function automatic logic [DATA_W-1:0] hex(input logic [3:0] n);
        logic [7:0] c;
        c = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
        return DATA_W'(c);
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] w,
                                       input logic [IW-1:0] i);
        logic [W-1:0] s;
        s = w >> {i, 2'b00};
        return s[3:0];
    endfunction

    assign xfer         = tx_valid_o & tx_ready_i;
    assign word_ready_o = (state == S_IDLE);
    assign busy_o       = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            idx        <= IDX_TOP;
            word_q     <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            word_q     <= word_nx;
            tx_data_o  <= data_nx;
            tx_valid_o <= valid_nx;
        end
    end

    // The state names the character currently presented on tx_data_o;
    // each transfer loads the following character so there are no bubbles.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        word_nx  = word_q;
        data_nx  = tx_data_o;
        valid_nx = tx_valid_o;
        case (state)
            S_IDLE: begin
                if (word_valid_i) begin
                    word_nx  = word_i;
                    valid_nx = 1'b1;
`ifdef IS_HEX_PREFIX_EN
                    state_nx = S_PFX0;
                    data_nx  = CH_0;
`else
                    state_nx = S_NIB;
                    data_nx  = hex(word_i[W-1 -: 4]);
`endif
                end
            end
`ifdef IS_HEX_PREFIX_EN
            S_PFX0: begin
                if (xfer) begin
                    state_nx = S_PFX1;
                    data_nx  = CH_X;
                end
            end
            S_PFX1: begin
                if (xfer) begin
                    state_nx = S_NIB;
                    data_nx  = hex(nib(word_q, IDX_TOP));
                end
            end
`endif
            S_NIB: begin
                if (xfer) begin
                    if (idx == '0) begin
                        state_nx = S_CR;
                        idx_nx   = IDX_TOP;
                        data_nx  = CH_CR;
                    end else begin
                        idx_nx  = idx - IW'(1);
                        data_nx = hex(nib(word_q, idx - IW'(1)));
                    end
                end
            end
            S_CR: begin
                if (xfer) begin
                    state_nx = S_LF;
                    data_nx  = CH_LF;
                end
            end
            S_LF: begin
                if (xfer) begin
                    state_nx = S_IDLE;
                    valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_is_uart_hex_tx_seq.sv
// Directed bench for is_uart_hex_tx_seq: 8-nibble and 1-nibble instances,
// table-driven words plus hand-written hold, reset and wrap sequences.
module tb_is_uart_hex_tx_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o;

    logic [3:0]  w1;
    logic        v1;
    logic        wr1;
    logic [7:0]  d1;
    logic        tv1;
    logic        r1;
    logic        b1;

    int total = 0;
    int bad   = 0;
    logic [7:0] expq[$];

    always #5 clk = ~clk;

    is_uart_hex_tx_seq #(.NIBBLES(8), .DATA_W(8)) u0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .busy_o(busy_o)
    );

    is_uart_hex_tx_seq #(.NIBBLES(1), .DATA_W(8)) u1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .word_i(w1), .word_valid_i(v1),
        .word_ready_o(wr1),
        .tx_data_o(d1), .tx_valid_o(tv1),
        .tx_ready_i(r1), .busy_o(b1)
    );

    typedef struct {
        logic [31:0]     word;
        bit              toggle;
        logic [0:9][7:0] bytes;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [0:9][7:0] b);
        expq.delete();
`ifdef IS_HEX_PREFIX_EN
        expq.push_back(8'h30);
        expq.push_back(8'h78);
`endif
        for (int i = 0; i < 10; i++) expq.push_back(b[i]);
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_idle_valid"}, 32'(tx_valid_o), 32'd0);
        chk({nm, "_idle_ready"}, 32'(word_ready_o), 32'd1);
        chk({nm, "_idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    // Entered at the negedge one cycle after accept.
    task automatic stream(input bit toggle, input string nm);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        while (k < expq.size() && cyc < 100) begin
            chk({nm, "_valid"}, 32'(tx_valid_o), 32'd1);
            chk({nm, "_busy"}, 32'(busy_o), 32'd1);
            chk({nm, "_data"}, 32'(tx_data_o), 32'(expq[k]));
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            tx_ready_i = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        tx_ready_i = 1'b0;
        chk({nm, "_count"}, 32'(k), 32'(expq.size()));
        idle_chk(nm);
    endtask

    initial begin
        tbl[0] = '{32'hDEADBEEF, 1'b0, {8'h44, 8'h45, 8'h41, 8'h44, 8'h42,
                                        8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A}};
        tbl[1] = '{32'h01234567, 1'b1, {8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                                        8'h35, 8'h36, 8'h37, 8'h0D, 8'h0A}};
        tbl[2] = '{32'h0000CAFE, 1'b0, {8'h30, 8'h30, 8'h30, 8'h30, 8'h43,
                                        8'h41, 8'h46, 8'h45, 8'h0D, 8'h0A}};

        rst_n = 1'b0;
        word_i = '0;
        word_valid_i = 1'b0;
        tx_ready_i = 1'b0;
        w1 = '0;
        v1 = 1'b0;
        r1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(word_ready_o), 32'd1);
        chk("rst_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_data", 32'(tx_data_o), 32'h00);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;

        // tx_ready with nothing valid must not disturb the idle state
        tx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        tx_ready_i = 1'b0;
        idle_chk("ready_ignored");
        chk("ready_ignored_data", 32'(tx_data_o), 32'h00);

        for (int t = 0; t < 3; t++) begin
            load(tbl[t].bytes);
            word_i = tbl[t].word;
            word_valid_i = 1'b1;
            @(negedge clk);
            word_valid_i = 1'b0;
            stream(tbl[t].toggle, $sformatf("vec%0d", t));
            @(negedge clk);
        end

        // valid held high: second word waits for the idle cycle after LF
        load({8'h38, 8'h39, 8'h41, 8'h42, 8'h43,
              8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A});
        word_i = 32'h89ABCDEF;
        word_valid_i = 1'b1;
        @(negedge clk);
        word_i = 32'h0000000F;
        stream(1'b0, "hold_w1");
        load({8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
              8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A});
        @(negedge clk);
        word_valid_i = 1'b0;
        stream(1'b0, "hold_w2");

        // async reset while the 4th character is stalled
        load(tbl[0].bytes);
        word_i = 32'hDEADBEEF;
        word_valid_i = 1'b1;
        @(negedge clk);
        word_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        tx_ready_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_data", 32'(tx_data_o), 32'(expq[3]));
        chk("rst_mid_pre_valid", 32'(tx_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_ready", 32'(word_ready_o), 32'd1);
        chk("rst_mid_data", 32'(tx_data_o), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk("rst_mid_after");
        load(tbl[1].bytes);
        word_i = 32'h01234567;
        word_valid_i = 1'b1;
        @(negedge clk);
        word_valid_i = 1'b0;
        stream(1'b0, "rst_next");

        // single-nibble instance: index wrap must not add a character
        expq.delete();
`ifdef IS_HEX_PREFIX_EN
        expq.push_back(8'h30);
        expq.push_back(8'h78);
`endif
        expq.push_back(8'h41);
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
        chk("n1_rst_ready", 32'(wr1), 32'd1);
        w1 = 4'hA;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        r1 = 1'b1;
        for (int k = 0; k < expq.size(); k++) begin
            chk("n1_valid", 32'(tv1), 32'd1);
            chk("n1_data", 32'(d1), 32'(expq[k]));
            @(negedge clk);
        end
        r1 = 1'b0;
        chk("n1_end_valid", 32'(tv1), 32'd0);
        chk("n1_end_ready", 32'(wr1), 32'd1);
        chk("n1_end_busy", 32'(b1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
